// File: rtl/el2_ifu_fetch_buf.sv
// el2_ifu_fetch_buf: fetch packet queue with a 16/32-bit instruction aligner and entry-free pulses.
// Optional macro RV_IFU_FB_BYPASS_EN lets an arriving packet feed the aligner in its arrival cycle.
module el2_ifu_fetch_buf #(
   parameter int FB_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exu_flush_final,
   input  logic [1:0]  ifu_fetch_val,
   input  logic [31:0] ifu_fetch_data,
   input  logic [30:0] ifu_fetch_pc,
   input  logic        ifu_fetch_err,
   input  logic        dec_i0_ready,
   output logic        ifu_i0_valid,
   output logic [31:0] ifu_i0_instr,
   output logic [30:0] ifu_i0_pc,
   output logic        ifu_i0_pc4,
   output logic        ifu_i0_icaf,
   output logic        ifu_fb_consume1,
   output logic        ifu_fb_consume2,
   output logic        ifu_fb_overflow
);
   localparam int PW = $clog2(FB_DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FB_DEPTH);

   typedef struct packed {
      logic [29:0] base;
      logic [15:0] hw0;
      logic [15:0] hw1;
      logic        v0;
      logic        v1;
      logic        err;
   } fb_entry_t;

   fb_entry_t       mem_q [FB_DEPTH];
   logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d, rp1;
   logic [PW:0]     count_q, count_d;
   logic            slot_q, slot_d;
   logic            ovf_q, ovf_d;

   fb_entry_t       in_ent, e0, e1;
   logic            e0_p, e1_p, wr_req, full, wr_ok;
   logic            f0, f1, is32, same_ent, raw_valid, advance, slot_n, out_en;
   logic [15:0]     hw_a, hw_b;
   logic [1:0]      nfree, adv_free;

   assign rp1    = rp_q + PW'(1);
   assign in_ent = '{base: ifu_fetch_pc[30:1], hw0: ifu_fetch_data[15:0],
                     hw1: ifu_fetch_data[31:16], v0: ifu_fetch_val[0],
                     v1: ifu_fetch_val[1], err: ifu_fetch_err};
   assign wr_req = |ifu_fetch_val;
   assign full   = (count_q == FULL_CNT);
   assign wr_ok  = wr_req & ~full;

   // The aligner looks at two consecutive entries: the head and the one behind it.
   always_comb begin
      e0   = mem_q[rp_q];
      e0_p = (count_q != '0);
      e1   = mem_q[rp1];
      e1_p = (count_q > (PW+1)'(1));
`ifdef RV_IFU_FB_BYPASS_EN
      if (count_q == '0) begin
         e0   = in_ent;
         e0_p = wr_req;
      end else if (count_q == (PW+1)'(1)) begin
         e1   = in_ent;
         e1_p = wr_req;
      end
`endif
   end

   // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
   always_comb begin
      f0        = slot_q | ~e0.v0;
      hw_a      = f0 ? e0.hw1 : e0.hw0;
      is32      = &hw_a[1:0];
      same_ent  = ~f0 & e0.v1;
      f1        = ~e1.v0;
      hw_b      = same_ent ? e0.hw1 : (f1 ? e1.hw1 : e1.hw0);
      raw_valid = e0_p & (~is32 | same_ent | e1_p);
      nfree     = 2'd1;
      slot_n    = 1'b0;
      if (!is32) begin
         if (same_ent) begin
            nfree  = 2'd0;
            slot_n = 1'b1;
         end
      end else if (!same_ent) begin
         if (!f1 && e1.v1) slot_n = 1'b1;
         else              nfree  = 2'd2;
      end
      advance  = raw_valid & dec_i0_ready;
      adv_free = advance ? nfree : 2'd0;
   end

   always_comb begin
      wp_d    = wp_q + PW'(wr_ok);
      rp_d    = rp_q + PW'(adv_free);
      slot_d  = advance ? slot_n : slot_q;
      count_d = count_q + (PW+1)'(wr_ok) - (PW+1)'(adv_free);
      ovf_d   = ovf_q | (wr_req & full);
   end

   assign out_en          = e0_p & ~rst;
   assign ifu_i0_valid    = raw_valid & ~rst;
   assign ifu_i0_instr    = out_en ? (is32 ? {hw_b, hw_a} : {16'h0000, hw_a}) : '0;
   assign ifu_i0_pc       = out_en ? {e0.base, f0} : '0;
   assign ifu_i0_pc4      = out_en & is32;
   assign ifu_i0_icaf     = out_en & (e0.err | (is32 & ~same_ent & e1_p & e1.err));
   assign ifu_fb_consume1 = ~rst & ~exu_flush_final & (adv_free == 2'd1);
   assign ifu_fb_consume2 = ~rst & ~exu_flush_final & (adv_free == 2'd2);
   assign ifu_fb_overflow = ~rst & ovf_q;

   // NOTE: only the entry valids are cleared; packet data is left unreset because count gates its use.
   always_ff @(posedge clk) begin
      if (rst || exu_flush_final) begin
         wp_q    <= '0;
         rp_q    <= '0;
         slot_q  <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < FB_DEPTH; i++) begin
            mem_q[i].v0 <= 1'b0;
            mem_q[i].v1 <= 1'b0;
         end
      end else begin
         if (wr_ok) mem_q[wp_q] <= in_ent;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         slot_q  <= slot_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end
endmodule

// File: tb/tb_el2_ifu_fetch_buf.sv
// Directed bench for el2_ifu_fetch_buf: expected instructions are queued as packets are driven
// and compared whenever decode accepts an instruction.
module tb_el2_ifu_fetch_buf;
   logic        clk;
   logic        rst;
   logic        exu_flush_final;
   logic [1:0]  ifu_fetch_val;
   logic [31:0] ifu_fetch_data;
   logic [30:0] ifu_fetch_pc;
   logic        ifu_fetch_err;
   logic        dec_i0_ready;
   logic        ifu_i0_valid;
   logic [31:0] ifu_i0_instr;
   logic [30:0] ifu_i0_pc;
   logic        ifu_i0_pc4;
   logic        ifu_i0_icaf;
   logic        ifu_fb_consume1;
   logic        ifu_fb_consume2;
   logic        ifu_fb_overflow;

   typedef struct {
      logic [31:0] instr;
      logic [30:0] pc;
      logic        pc4;
      logic        icaf;
      logic        c1;
      logic        c2;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   el2_ifu_fetch_buf #(.FB_DEPTH(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .exu_flush_final (exu_flush_final),
      .ifu_fetch_val   (ifu_fetch_val),
      .ifu_fetch_data  (ifu_fetch_data),
      .ifu_fetch_pc    (ifu_fetch_pc),
      .ifu_fetch_err   (ifu_fetch_err),
      .dec_i0_ready    (dec_i0_ready),
      .ifu_i0_valid    (ifu_i0_valid),
      .ifu_i0_instr    (ifu_i0_instr),
      .ifu_i0_pc       (ifu_i0_pc),
      .ifu_i0_pc4      (ifu_i0_pc4),
      .ifu_i0_icaf     (ifu_i0_icaf),
      .ifu_fb_consume1 (ifu_fb_consume1),
      .ifu_fb_consume2 (ifu_fb_consume2),
      .ifu_fb_overflow (ifu_fb_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] instr, input logic [30:0] pc, input logic pc4,
                       input logic icaf, input logic c1, input logic c2);
      sb_q.push_back('{instr: instr, pc: pc, pc4: pc4, icaf: icaf, c1: c1, c2: c2});
   endtask

   // Called at posedge+1; holds the packet for one clock edge.
   task automatic send(input logic [1:0] val, input logic [30:0] pc, input logic [31:0] data,
                       input logic err);
      ifu_fetch_val  = val;
      ifu_fetch_pc   = pc;
      ifu_fetch_data = data;
      ifu_fetch_err  = err;
      @(posedge clk); #1;
      ifu_fetch_val  = 2'b00;
      ifu_fetch_err  = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      check(tag, 32'(sb_q.size()), 32'd0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         if (ifu_i0_valid && dec_i0_ready && !exu_flush_final) begin
            if (sb_q.size() == 0) begin
               check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
               e = sb_q.pop_front();
               check("instr", ifu_i0_instr, e.instr);
               check("pc",    32'(ifu_i0_pc), 32'(e.pc));
               check("pc4",   32'(ifu_i0_pc4), 32'(e.pc4));
               check("icaf",  32'(ifu_i0_icaf), 32'(e.icaf));
               check("consume1", 32'(ifu_fb_consume1), 32'(e.c1));
               check("consume2", 32'(ifu_fb_consume2), 32'(e.c2));
            end
         end else begin
            check("idle_consume", 32'({ifu_fb_consume2, ifu_fb_consume1}), 32'd0);
         end
      end
   end

   initial begin
      rst             = 1'b1;
      exu_flush_final = 1'b0;
      ifu_fetch_val   = 2'b00;
      ifu_fetch_data  = '0;
      ifu_fetch_pc    = '0;
      ifu_fetch_err   = 1'b0;
      dec_i0_ready    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(ifu_i0_valid), 32'd0);
      check("rst_instr", ifu_i0_instr, 32'd0);
      check("rst_consume", 32'({ifu_fb_consume2, ifu_fb_consume1}), 32'd0);
      check("rst_overflow", 32'(ifu_fb_overflow), 32'd0);
      rst = 1'b0;

      // Two 16-bit instructions in one packet.
      push(32'h0000_0001, 31'h800, 1'b0, 1'b0, 1'b0, 1'b0);
      push(32'h0000_0001, 31'h801, 1'b0, 1'b0, 1'b1, 1'b0);
      send(2'b11, 31'h800, 32'h0001_0001, 1'b0);
      drain("drain_two16");
      check("empty_after_two16", 32'(ifu_i0_valid), 32'd0);

      // One 32-bit instruction filling a whole packet.
      push(32'h0000_0013, 31'h1000, 1'b1, 1'b0, 1'b1, 1'b0);
      send(2'b11, 31'h1000, 32'h0000_0013, 1'b0);
      drain("drain_32");

      // 32-bit straddling two entries, without and with a fault on the second entry.
      for (int e = 0; e < 2; e++) begin
         push(32'h0000_0093, 31'h1801, 1'b1, 1'(e), 1'b1, 1'b0);
         push(32'h0000_0001, 31'h1803, 1'b0, 1'(e), 1'b1, 1'b0);
         send(2'b10, 31'h1800, 32'h0093_0000, 1'b0);
         send(2'b11, 31'h1802, 32'h0001_0000, 1'(e));
         drain("drain_straddle");
      end

      // 32-bit built from two lower-only entries frees both at once.
      push(32'h0000_0013, 31'h2000, 1'b1, 1'b0, 1'b0, 1'b1);
      send(2'b01, 31'h2000, 32'h0000_0013, 1'b0);
      send(2'b01, 31'h2002, 32'h0000_0000, 1'b0);
      drain("drain_consume2");

      // Fill while decode stalls, then overflow, then flush.
      dec_i0_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         send(2'b11, 31'h3000 + 31'(2 * i), {16'(32'h11 + 2 * i), 16'(32'h10 + 2 * i)}, 1'b0);
      check("full_no_overflow", 32'(ifu_fb_overflow), 32'd0);
      send(2'b11, 31'h3100, 32'hFFFF_FFFF, 1'b0);
      check("overflow_set", 32'(ifu_fb_overflow), 32'd1);
      check("full_valid", 32'(ifu_i0_valid), 32'd1);
      check("full_head_instr", ifu_i0_instr, 32'h0000_0010);
      check("full_head_pc", 32'(ifu_i0_pc), 32'h3000);
      exu_flush_final = 1'b1;
      @(posedge clk); #1;
      exu_flush_final = 1'b0;
      check("flush_overflow", 32'(ifu_fb_overflow), 32'd0);
      check("flush_valid", 32'(ifu_i0_valid), 32'd0);
      dec_i0_ready = 1'b1;
      push(32'h0000_0004, 31'h2800, 1'b0, 1'b0, 1'b0, 1'b0);
      push(32'h0000_0005, 31'h2801, 1'b0, 1'b0, 1'b1, 1'b0);
      send(2'b11, 31'h2800, 32'h0005_0004, 1'b0);
      drain("drain_after_flush");

      // Reset in the middle of operation.
      dec_i0_ready = 1'b0;
      send(2'b11, 31'h2900, 32'h0007_0006, 1'b0);
      check("pre_rst_valid", 32'(ifu_i0_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", 32'(ifu_i0_valid), 32'd0);
      check("mid_rst_instr", ifu_i0_instr, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("post_rst_valid", 32'(ifu_i0_valid), 32'd0);
      dec_i0_ready = 1'b1;
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/el2_ifu_fetch_buf.md
Name: el2_ifu_fetch_buf

Overview:
- Fetch buffer and aligner directly downstream of the fetch-pipe controller.
- Captures 32-bit fetch packets returned in F stage into a small queue of halfword-granular entries.
- Extracts one 16- or 32-bit instruction per cycle for decode.
- Reports freed entries as consume1/consume2 pulses, which feed back to the fetch controller's buffer-occupancy model.

Parameters:
- FB_DEPTH, 4, number of packet entries; must be a power of two, ≥2.

Ports:
- clk  in  1  core clock
- rst  in  1  reset
- exu_flush_final  in  1  flush; empties buffer
- ifu_fetch_val  in  2  halfword valids of returning packet ([0]=lower, [1]=upper); 0 = no write
- ifu_fetch_data  in  32  packet data, lower halfword in [15:0]
- ifu_fetch_pc  in  31  packet address [31:1]; bit1 ignored, entry base = {pc[31:2],1'b0}
- ifu_fetch_err  in  1  access fault for whole packet
- dec_i0_ready  in  1  decode accepts instruction this cycle
- ifu_i0_valid  out  1  aligned instruction available
- ifu_i0_instr  out  32  instruction; 16-bit forms zero-extended
- ifu_i0_pc  out  31  instruction address [31:1]
- ifu_i0_pc4  out  1  1 = 32-bit instruction
- ifu_i0_icaf  out  1  any contributing halfword carried fault
- ifu_fb_consume1  out  1  exactly one entry freed this cycle
- ifu_fb_consume2  out  1  two entries freed this cycle
- ifu_fb_overflow  out  1  write attempted while full (sticky until rst/flush)

Behaviour:
- Single clock, clk. Synchronous, active-high reset rst.
- Reset: all entries invalid, pointers 0, every output 0.
- Storage: circular queue of FB_DEPTH entries, each {base pc[31:2], hw0, hw1, v0, v1, err}. Write pointer wp, read pointer rp, read slot s (0/1).
- Write:
  - Any ifu_fetch_val != 0 writes entry wp: v = val, err = ifu_fetch_err.
  - wp increments modulo FB_DEPTH. No write on val == 0.
- Read slot selection:
  - Current halfword = first valid slot at or after s in entry rp.
  - If that entry has no remaining valid slot, it is freed and the read moves to the next entry.
- Length: halfword[1:0] == 2'b11 → 32-bit. Upper halfword = next valid halfword, either the following slot or the first valid slot of entry rp+1.
- ifu_i0_valid = first halfword present and, if 32-bit, second halfword present.
- Outputs are combinational from registered state.
  - ifu_i0_pc = {base, slot}.
  - icaf = OR of err of every entry contributing.
- Advance on ifu_i0_valid & dec_i0_ready:
  - Consume 1 or 2 halfwords.
  - Free each entry whose valid halfwords are now all consumed.
  - At most 2 frees per cycle: consume1 = one, consume2 = two. Both registered state updates take effect next cycle; pulses are combinational in the same cycle.
- Simultaneous write and free:
  - Both applied; the freed slot can be rewritten only the following cycle.
  - Occupancy = count, range 0..FB_DEPTH.
- Full (count == FB_DEPTH) with write: write dropped, overflow set. The fetch controller's model prevents this in normal operation.
- Empty: i0_valid = 0, no pulses.
- Flush (exu_flush_final):
  - Highest priority.
  - Clears all valids, pointers, slot and overflow. Suppresses consume pulses and any same-cycle write.
  - i0_valid still reflects pre-flush state combinationally but must be ignored by decode.
- rst mid-operation: identical to flush, plus outputs forced to 0.
- Pointer wrap: rp/wp modulo FB_DEPTH; count distinguishes full from empty.

Optional Feature:
- Macro: RV_IFU_FB_BYPASS_EN.
- Defined: when the buffer is empty (or holds only a dangling lower halfword of a 32-bit instruction), the incoming packet feeds the aligner the same cycle, giving 0-cycle latency. If consumed entirely, the packet is not written. Consume pulses count bypassed packets as freed entries.
- Undefined: data is visible on i0 one cycle after the write; no combinational path from ifu_fetch_* to ifu_i0_*.

Test Plan:
- Reset, then packet val=11, pc=0x1000>>1, data=0x00010001 (two 16-bit), ready=1
  → without bypass: cycle+1 instr=0x0001, pc=0x1000; cycle+2 pc=0x1002, consume1=1; then valid=0.
- Packet data=0x00000013 (32-bit addi) val=11 → one instr=0x00000013, pc4=1, consume1=1 same cycle.
- 32-bit straddle: entry A val=10, hw1=0x0093; entry B val=11, data=0x00010000
  → instr=0x00000093, pc=A+2; A freed (consume1); next cycle 16-bit 0x0001, frees B.
- Two val=01 entries holding hw 0x0013 and 0x0000
  → single 32-bit instr=0x00000013 frees both: consume2=1.
- Fill 4 entries with ready=0, send 5th → overflow=1, contents unchanged. Flush → overflow=0, valid=0, next packet accepted at entry 0.
- ifu_fetch_err=1 on entry B of the straddle case → icaf=1 on the straddling instruction. With RV_IFU_FB_BYPASS_EN, the first case gives instr=0x0001 in the write cycle.
